// File: rtl/cube_vga_pkg.sv
// Shared types, the cube-net slot table and the sticker palette for the cube net renderer.
package cube_vga_pkg;

  localparam int unsigned FACE_COUNT = 6;
  localparam int unsigned IDX_W      = 9;

  typedef enum logic [2:0] {FaceU, FaceL, FaceF, FaceR, FaceB, FaceD} face_e;

  typedef struct packed {
    logic  hit;
    face_e face;
  } slot_t;

  // Position of each face in the 4x3 cross, indexed by face_e
  localparam int unsigned SLOT_COL [FACE_COUNT] = '{1, 0, 1, 2, 3, 1};
  localparam int unsigned SLOT_ROW [FACE_COUNT] = '{0, 1, 1, 1, 1, 2};

  localparam logic [23:0] PAL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] PAL_ORANGE  = 24'hFF4000;
  localparam logic [23:0] PAL_GREEN   = 24'h00FF00;
  localparam logic [23:0] PAL_RED     = 24'hFF0000;
  localparam logic [23:0] PAL_BLUE    = 24'h0000FF;
  localparam logic [23:0] PAL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] PAL_INVALID = 24'hFF00FF;

  function automatic logic [23:0] palette(input logic [2:0] code);
    logic [23:0] c;
    case (code)
      3'd0:    c = PAL_WHITE;
      3'd1:    c = PAL_ORANGE;
      3'd2:    c = PAL_GREEN;
      3'd3:    c = PAL_RED;
      3'd4:    c = PAL_BLUE;
      3'd5:    c = PAL_YELLOW;
      default: c = PAL_INVALID;
    endcase
    return c;
  endfunction

  function automatic slot_t face_at(input logic [1:0] scol, input logic [1:0] srow);
    slot_t r;
    r.hit  = 1'b0;
    r.face = FaceU;
    for (int f = 0; f < FACE_COUNT; f++) begin
      if (scol == 2'(SLOT_COL[f]) && srow == 2'(SLOT_ROW[f])) begin
        r.hit  = 1'b1;
        r.face = face_e'(3'(f));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cube_net_tracker.sv
// Stage S1: follows the raster with offset/cell counters and decodes face, sticker index and gap.
module cube_net_tracker
  import cube_vga_pkg::*;
#(
  parameter int unsigned CUBE_N     = 3,
  parameter int unsigned STICKER_PX = 20,
  parameter int unsigned GAP_PX     = 2,
  parameter int unsigned ORIGIN_X   = 80,
  parameter int unsigned ORIGIN_Y   = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  output logic             s1_valid,
  output logic             s1_hit,
  output logic             s1_gap,
  output logic [IDX_W-1:0] s1_idx
);

  localparam int unsigned P      = STICKER_PX + GAP_PX;
  localparam int unsigned OFF_W  = $clog2(P);
  localparam int unsigned CELL_W = 5;
  localparam logic [OFF_W-1:0]  OFF_LAST = OFF_W'(P - 1);
  localparam logic [OFF_W-1:0]  OFF_GAP  = OFF_W'(STICKER_PX);
  localparam logic [CELL_W-1:0] H_END    = CELL_W'(4 * CUBE_N);
  localparam logic [CELL_W-1:0] V_END    = CELL_W'(3 * CUBE_N);
  localparam logic [9:0]        X0       = 10'(ORIGIN_X);
  localparam logic [9:0]        Y0       = 10'(ORIGIN_Y);

  logic [OFF_W-1:0]  h_off_q, h_off_d, v_off_q, v_off_d;
  logic [CELL_W-1:0] h_cell_q, h_cell_d, v_cell_q, v_cell_d;
  logic [CELL_W-1:0] col_base, row_base, col, row;
  logic [1:0]        scol, srow;
  logic              outside, hit_d, gap_d;
  logic [IDX_W-1:0]  idx_d;
  slot_t             slot;

  always_comb begin
    h_off_d  = h_off_q;
    h_cell_d = h_cell_q;
    v_off_d  = v_off_q;
    v_cell_d = v_cell_q;
    if (pix_valid) begin
      if (pix_x == X0) begin
        h_off_d  = '0;
        h_cell_d = '0;
      end else if (h_off_q == OFF_LAST) begin
        h_off_d = '0;
        if (h_cell_q < H_END) h_cell_d = h_cell_q + CELL_W'(1);
      end else begin
        h_off_d = h_off_q + OFF_W'(1);
      end
      // Vertical state advances once per line, on its first pixel
      if (pix_x == '0) begin
        if (pix_y == Y0) begin
          v_off_d  = '0;
          v_cell_d = '0;
        end else if (v_off_q == OFF_LAST) begin
          v_off_d = '0;
          if (v_cell_q < V_END) v_cell_d = v_cell_q + CELL_W'(1);
        end else begin
          v_off_d = v_off_q + OFF_W'(1);
        end
      end
    end
  end

  always_comb begin
    scol     = '0;
    col_base = '0;
    srow     = '0;
    row_base = '0;
    for (int k = 1; k < 4; k++) begin
      if (h_cell_d >= CELL_W'(k * CUBE_N)) begin
        scol     = 2'(k);
        col_base = CELL_W'(k * CUBE_N);
      end
    end
    for (int k = 1; k < 3; k++) begin
      if (v_cell_d >= CELL_W'(k * CUBE_N)) begin
        srow     = 2'(k);
        row_base = CELL_W'(k * CUBE_N);
      end
    end
    col     = h_cell_d - col_base;
    row     = v_cell_d - row_base;
    slot    = face_at(scol, srow);
    outside = (pix_x < X0) || (pix_y < Y0) || (h_cell_d >= H_END) || (v_cell_d >= V_END);
    hit_d   = pix_valid && !outside && slot.hit;
    gap_d   = (h_off_d >= OFF_GAP) || (v_off_d >= OFF_GAP);
    idx_d   = '0;
    if (hit_d) begin
      idx_d = IDX_W'(32'(slot.face) * CUBE_N * CUBE_N + 32'(row) * CUBE_N + 32'(col));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_off_q  <= '0;
      h_cell_q <= '0;
      v_off_q  <= '0;
      v_cell_q <= '0;
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_gap   <= 1'b0;
      s1_idx   <= '0;
    end else begin
      h_off_q  <= h_off_d;
      h_cell_q <= h_cell_d;
      v_off_q  <= v_off_d;
      v_cell_q <= v_cell_d;
      s1_valid <= pix_valid;
      s1_hit   <= hit_d;
      s1_gap   <= gap_d;
      s1_idx   <= idx_d;
    end
  end

endmodule

// File: rtl/cube_net_renderer.sv
// Framebuffer-free cube-net renderer with double-buffered sticker colours.
// Optional blinking sticker cursor is enabled by defining CUBE_CURSOR_EN.
module cube_net_renderer
  import cube_vga_pkg::*;
#(
  parameter int unsigned CUBE_N     = 3,
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned STICKER_PX = 20,
  parameter int unsigned GAP_PX     = 2,
  parameter int unsigned ORIGIN_X   = 80,
  parameter int unsigned ORIGIN_Y   = 60,
  parameter logic [23:0] GAP_RGB    = 24'h202020
) (
  input  logic                                       clk,
  input  logic                                       rst,
`ifdef CUBE_CURSOR_EN
  input  logic                                       cursor_on,
  input  logic [7:0]                                 cursor_idx,
`endif
  input  logic                                       pix_valid,
  input  logic [9:0]                                 pix_x,
  input  logic [9:0]                                 pix_y,
  input  logic                                       frame_done,
  input  logic                                       color_load,
  input  logic [FACE_COUNT*CUBE_N*CUBE_N*COLOR_W-1:0] color_in,
  output logic                                       color_busy,
  output logic                                       rgb_valid,
  output logic [23:0]                                rgb
);

  localparam int unsigned NUM_STICKERS = FACE_COUNT * CUBE_N * CUBE_N;
  localparam int unsigned VEC_W        = NUM_STICKERS * COLOR_W;

  function automatic logic [VEC_W-1:0] solved_vec();
    logic [VEC_W-1:0] v;
    v = '0;
    for (int s = 0; s < NUM_STICKERS; s++) begin
      v[s*COLOR_W +: COLOR_W] = COLOR_W'(s / (CUBE_N * CUBE_N));
    end
    return v;
  endfunction

  localparam logic [VEC_W-1:0] SOLVED = solved_vec();

  logic             s1_valid, s1_hit, s1_gap;
  logic [IDX_W-1:0] s1_idx;
  logic [VEC_W-1:0] pending_q, displayed_q;
  logic [COLOR_W-1:0] code;
  logic [23:0]      sticker_rgb, rgb_d;

  cube_net_tracker #(
    .CUBE_N     (CUBE_N),
    .STICKER_PX (STICKER_PX),
    .GAP_PX     (GAP_PX),
    .ORIGIN_X   (ORIGIN_X),
    .ORIGIN_Y   (ORIGIN_Y)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .s1_valid  (s1_valid),
    .s1_hit    (s1_hit),
    .s1_gap    (s1_gap),
    .s1_idx    (s1_idx)
  );

`ifdef CUBE_CURSOR_EN
  logic [4:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 5'd1;
    end
  end
`endif

  always_comb begin
    code        = displayed_q[s1_idx*COLOR_W +: COLOR_W];
    sticker_rgb = palette(3'(code));
`ifdef CUBE_CURSOR_EN
    if (cursor_on && s1_idx == IDX_W'(cursor_idx) && frame_cnt_q[4]) begin
      sticker_rgb = sticker_rgb ^ 24'hFFFFFF;
    end
`endif
    rgb_d = '0;
    if (s1_valid && s1_hit) begin
      rgb_d = s1_gap ? GAP_RGB : sticker_rgb;
    end
  end

  // A load coinciding with frame_done commits the previous pending value first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb         <= '0;
      rgb_valid   <= 1'b0;
      pending_q   <= '0;
      color_busy  <= 1'b0;
      displayed_q <= SOLVED;
    end else begin
      rgb       <= rgb_d;
      rgb_valid <= s1_valid;
      if (frame_done && color_busy) displayed_q <= pending_q;
      if (color_load) begin
        pending_q  <= color_in;
        color_busy <= 1'b1;
      end else if (frame_done) begin
        color_busy <= 1'b0;
      end
    end
  end

endmodule
